// File: rtl/digit_overlay_pkg.sv
// Shared types and constants for the numeric overlay sequencer
// and its pixel pipeline.
package digit_overlay_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_STROBE,
        S_WAIT,
        S_LATCH,
        S_DISPLAY
    } state_t;

    localparam int GLYPH_W    = 8;
    localparam int GLYPH_H    = 8;
    localparam int NUM_DIGITS = 2;
    localparam int ROM_AW     = 7;
    localparam int VAL_W      = 6;
    localparam int DIG_W      = 4;

    function automatic logic [2:0] bit_index(input logic [2:0] col);
        return 3'd7 - col;
    endfunction

endpackage

// File: rtl/overlay_pix_pipe.sv
// Window test, glyph addressing and pixel bit select for the overlay.
// Two register stages around a registered character ROM.
module overlay_pix_pipe
    import digit_overlay_pkg::*;
#(
    parameter logic [9:0] X0       = 10'd16,
    parameter logic [9:0] Y0       = 10'd16,
    parameter int         SCALE_SH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic              i_valid,
    input  logic [9:0]        i_hcount,
    input  logic [9:0]        i_vcount,
    input  logic [7:0]        i_digits,
    input  logic [7:0]        i_rom_data,
    output logic [ROM_AW-1:0] o_rom_addr,
    output logic              o_pix_on
);

    localparam logic [10:0] WIN_W = 11'(GLYPH_W * NUM_DIGITS) << SCALE_SH;
    localparam logic [10:0] WIN_H = 11'(GLYPH_H) << SCALE_SH;

    logic [10:0]       w_dx;
    logic [10:0]       w_dy;
    logic [3:0]        w_col;
    logic [2:0]        w_row;
    logic [DIG_W-1:0]  w_nib;
    logic              w_inside;

    logic [ROM_AW-1:0] r_addr;
    logic              r_in0;
    logic              r_in1;
    logic [2:0]        r_bit0;
    logic [2:0]        r_bit1;
    logic              r_pix;

    // Negative offsets wrap to >= 1024 and fail the unsigned bound.
    assign w_dx     = {1'b0, i_hcount} - {1'b0, X0};
    assign w_dy     = {1'b0, i_vcount} - {1'b0, Y0};
    assign w_inside = (w_dx < WIN_W) && (w_dy < WIN_H);
    assign w_col    = 4'(w_dx >> SCALE_SH);
    assign w_row    = 3'(w_dy >> SCALE_SH);
    assign w_nib    = w_col[3] ? i_digits[3:0] : i_digits[7:4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_in0  <= 1'b0;
            r_in1  <= 1'b0;
            r_bit0 <= 3'd0;
            r_bit1 <= 3'd0;
            r_pix  <= 1'b0;
        end else begin
            if (w_inside)
                r_addr <= {w_nib, w_row};
            r_in0  <= w_inside;
            r_bit0 <= bit_index(w_col[2:0]);
            r_in1  <= r_in0;
            r_bit1 <= r_bit0;
            r_pix  <= r_in1 & i_valid & i_en & i_rom_data[r_bit1];
        end
    end

    assign o_rom_addr = r_addr;
    assign o_pix_on   = r_pix;

endmodule

// File: rtl/digit_overlay_ctrl.sv
// Per-frame capture/convert/latch sequencer for the numeric overlay,
// plus the bring-up frame counter.
module digit_overlay_ctrl
    import digit_overlay_pkg::*;
#(
    parameter logic [9:0] X0       = 10'd16,
    parameter logic [9:0] Y0       = 10'd16,
    parameter int         SCALE_SH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              newframe,
    input  logic              test_mode,
    input  logic [VAL_W-1:0]  value_in,
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    input  logic [7:0]        digits_in,
    input  logic [7:0]        rom_data,
    output logic [VAL_W-1:0]  conv_value,
    output logic              conv_strobe,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              pix_on,
    output logic [3:0]        test_count
);

    state_t           r_state;
    state_t           w_next;
    logic [VAL_W-1:0] r_conv_value;
    logic             r_strobe;
    logic [3:0]       r_test_count;
    logic [7:0]       r_digits;
    logic             r_valid;

    always_comb begin
        w_next = r_state;
        if (!en) begin
            w_next = S_IDLE;
        end else if (newframe) begin
            w_next = S_CAPTURE;
        end else begin
            unique case (r_state)
                S_CAPTURE: w_next = S_STROBE;
                S_STROBE:  w_next = S_WAIT;
                S_WAIT:    w_next = S_LATCH;
                S_LATCH:   w_next = S_DISPLAY;
                default:   w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_conv_value <= '0;
            r_strobe     <= 1'b0;
            r_test_count <= 4'd0;
            r_digits     <= 8'd0;
            r_valid      <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_strobe <= (w_next == S_STROBE);
            if (en && r_state == S_CAPTURE) begin
                r_conv_value <= test_mode ? {2'b00, r_test_count} : value_in;
                r_test_count <= r_test_count + 4'd1;
            end
            // A restart in LATCH discards the pending conversion.
            if (en && !newframe && r_state == S_LATCH) begin
                r_digits <= digits_in;
                r_valid  <= 1'b1;
            end
        end
    end

    overlay_pix_pipe #(
        .X0       (X0),
        .Y0       (Y0),
        .SCALE_SH (SCALE_SH)
    ) u_pix (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (en),
        .i_valid    (r_valid),
        .i_hcount   (hcount),
        .i_vcount   (vcount),
        .i_digits   (r_digits),
        .i_rom_data (rom_data),
        .o_rom_addr (rom_addr),
        .o_pix_on   (pix_on)
    );

    assign conv_value  = r_conv_value;
    assign conv_strobe = r_strobe;
    assign test_count  = r_test_count;

endmodule

// File: tb/tb_digit_overlay_ctrl.sv
// Directed bench for digit_overlay_ctrl with converter and ROM models
// and queue-based scoreboards for conversions and overlay pixels.
module tb_digit_overlay_ctrl;

    localparam int X0 = 16;
    localparam int Y0 = 16;
    localparam int SH = 0;
    localparam int OFF = 1000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       newframe;
    logic       test_mode;
    logic [5:0] value_in;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic [7:0] digits_in = 8'd0;
    logic [7:0] rom_data = 8'd0;
    logic [5:0] conv_value;
    logic       conv_strobe;
    logic [6:0] rom_addr;
    logic       pix_on;
    logic [3:0] test_count;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    logic [5:0] cv_q[$];
    logic [1:0] pix_q[$];
    logic       sb_chk = 1'b1;
    logic [7:0] m_digits = 8'd0;
    logic       m_valid = 1'b0;
    logic [3:0] m_tc = 4'd0;

    digit_overlay_ctrl #(
        .X0       (10'(X0)),
        .Y0       (10'(Y0)),
        .SCALE_SH (SH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .newframe    (newframe),
        .test_mode   (test_mode),
        .value_in    (value_in),
        .hcount      (hcount),
        .vcount      (vcount),
        .digits_in   (digits_in),
        .rom_data    (rom_data),
        .conv_value  (conv_value),
        .conv_strobe (conv_strobe),
        .rom_addr    (rom_addr),
        .pix_on      (pix_on),
        .test_count  (test_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] glyph(input logic [6:0] a);
        return 8'({1'b0, a} * 8'd29) ^ 8'h3C;
    endfunction

    function automatic logic [7:0] oct(input logic [5:0] v);
        return {1'b0, v[5:3], 1'b0, v[2:0]};
    endfunction

    // Octal converter: samples while strobed, settles by LATCH.
    always @(posedge clk)
        if (conv_strobe) digits_in <= oct(conv_value);

    // Registered character ROM with one cycle of latency.
    always @(posedge clk)
        rom_data <= glyph(rom_addr);

    function automatic logic exp_pix(input int h, input int v);
        int dx, dy, col, row;
        logic [3:0] nib;
        logic [7:0] g;
        dx = h - X0;
        dy = v - Y0;
        if (!(m_valid && en)) return 1'b0;
        if (dx < 0 || dx >= (16 << SH) || dy < 0 || dy >= (8 << SH))
            return 1'b0;
        col = dx >> SH;
        row = (dy >> SH) % 8;
        nib = (col >= 8) ? m_digits[3:0] : m_digits[7:4];
        g = glyph({nib, 3'(row)});
        return g[7 - (col % 8)];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [1:0] e;
        pix_q.push_back({sb_chk, exp_pix(int'(hcount), int'(vcount))});
        @(posedge clk);
        #1;
        if (conv_strobe) begin
            strobe_cnt++;
            if (cv_q.size() == 0) chk("unexpected_strobe", 32'(conv_strobe), 0);
            else chk("conv_value", 32'(conv_value), 32'(cv_q.pop_front()));
        end
        if (pix_q.size() == 3) begin
            e = pix_q.pop_front();
            if (e[1]) chk("pix_on", 32'(pix_on), 32'(e[0]));
        end
    endtask

    task automatic push_cv();
        logic [5:0] cv;
        cv = test_mode ? {2'b00, m_tc} : value_in;
        cv_q.push_back(cv);
        m_tc = m_tc + 4'd1;
    endtask

    task automatic frame();
        logic [5:0] cv;
        push_cv();
        cv = cv_q[cv_q.size() - 1];
        newframe = 1'b1;
        tick();
        newframe = 1'b0;
        chk("strobe_early", 32'(conv_strobe), 0);
        tick();
        chk("strobe_n2", 32'(conv_strobe), 1);
        tick();
        chk("strobe_drop", 32'(conv_strobe), 0);
        tick();
        tick();
        m_digits = oct(cv);
        m_valid = 1'b1;
        chk("test_count", 32'(test_count), 32'(m_tc));
    endtask

    task automatic sweep();
        for (int v = Y0 - 1; v <= Y0 + (8 << SH); v++) begin
            for (int h = X0 - 2; h <= X0 + (16 << SH) + 1; h++) begin
                hcount = 10'(h);
                vcount = 10'(v);
                tick();
            end
        end
        hcount = 10'd0;
        vcount = 10'(Y0);
        tick();
        hcount = 10'd1023;
        tick();
        hcount = 10'(OFF);
        vcount = 10'(OFF);
        repeat (3) tick();
    endtask

    initial begin
        int s;
        int hl, vl;
        logic found;
        rst_n = 1'b0;
        en = 1'b1;
        newframe = 1'b0;
        test_mode = 1'b0;
        value_in = 6'o53;
        hcount = 10'(OFF);
        vcount = 10'(OFF);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_conv_value", 32'(conv_value), 0);
        chk("rst_strobe", 32'(conv_strobe), 0);
        chk("rst_rom_addr", 32'(rom_addr), 0);
        chk("rst_pix_on", 32'(pix_on), 0);
        chk("rst_test_count", 32'(test_count), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // No conversion yet: the window must stay dark.
        sweep();

        repeat (3) frame();
        hcount = 10'(X0);
        vcount = 10'(Y0);
        tick();
        chk("rom_addr_hi", 32'(rom_addr), 32'({4'd5, 3'd0}));
        hcount = 10'(X0 + 8);
        tick();
        chk("rom_addr_lo", 32'(rom_addr), 32'({4'd3, 3'd0}));
        hcount = 10'(OFF);
        vcount = 10'(OFF);
        repeat (3) tick();
        sweep();

        found = 1'b0;
        hl = 0;
        vl = 0;
        for (int v = Y0; v < Y0 + 8; v++)
            for (int h = X0; h < X0 + 16; h++)
                if (!found && exp_pix(h, v)) begin
                    found = 1'b1;
                    hl = h;
                    vl = v;
                end
        chk("lit_found", 32'(found), 1);
        sb_chk = 1'b0;
        hcount = 10'(hl);
        vcount = 10'(vl);
        repeat (3) tick();
        chk("lit_before_en_drop", 32'(pix_on), 1);
        en = 1'b0;
        tick();
        chk("pix_off_after_en_drop", 32'(pix_on), 0);
        s = strobe_cnt;
        repeat (2) begin
            newframe = 1'b1;
            tick();
            newframe = 1'b0;
            repeat (6) tick();
        end
        chk("no_strobe_when_disabled", 32'(strobe_cnt), 32'(s));
        chk("test_count_frozen", 32'(test_count), 32'(m_tc));
        en = 1'b1;
        repeat (3) tick();
        chk("old_digits_after_reenable", 32'(pix_on), 1);
        hcount = 10'(OFF);
        vcount = 10'(OFF);
        repeat (3) tick();
        sb_chk = 1'b1;

        test_mode = 1'b1;
        repeat (17) frame();
        sweep();

        s = strobe_cnt;
        push_cv();
        newframe = 1'b1;
        tick();
        newframe = 1'b0;
        tick();
        push_cv();
        newframe = 1'b1;
        tick();
        newframe = 1'b0;
        repeat (6) tick();
        chk("restart_strobes", 32'(strobe_cnt - s), 2);
        chk("restart_test_count", 32'(test_count), 32'(m_tc));
        chk("restart_queue_empty", 32'(cv_q.size()), 0);
        m_digits = oct(6'({2'b00, m_tc - 4'd1}));
        sweep();

        push_cv();
        newframe = 1'b1;
        tick();
        newframe = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_strobe", 32'(conv_strobe), 0);
        chk("async_rst_test_count", 32'(test_count), 0);
        chk("async_rst_pix_on", 32'(pix_on), 0);
        @(negedge clk);
        rst_n = 1'b1;
        pix_q.delete();
        cv_q.delete();
        m_valid = 1'b0;
        m_digits = 8'd0;
        m_tc = 4'd0;
        s = strobe_cnt;
        repeat (6) tick();
        chk("no_strobe_after_rst", 32'(strobe_cnt), 32'(s));
        sweep();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
